// File: rtl/alu_issue_ctrl_pkg.sv
// +---------------------------------------------------------------------------+
// | alu_issue_ctrl_pkg: state encoding, ALU select codes, divider latency.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package alu_issue_ctrl_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    DIV_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [2:0] SEL_ADDSUB = 3'b000;
  localparam logic [2:0] SEL_MUL    = 3'b001;
  localparam logic [2:0] SEL_DIV    = 3'b010;
  localparam logic [2:0] SEL_SLL    = 3'b011;
  localparam logic [2:0] SEL_SRL    = 3'b100;
  localparam logic [2:0] SEL_OR     = 3'b101;
  localparam logic [2:0] SEL_XOR    = 3'b110;
  localparam logic [2:0] SEL_AND    = 3'b111;

  // Shared with the divider so both sides agree on its run length.
  localparam int DIV_LATENCY_DEFAULT = 64;

endpackage

`default_nettype wire

// File: rtl/alu_wait_counter.sv
// +---------------------------------------------------------------------------+
// | alu_wait_counter: loadable down-counter with zero flag.                   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module alu_wait_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +---------------------------------------------------------------------------+
// | alu_issue_ctrl: issues one op at a time to the execute-stage ALU, waits   |
// | its latency, and returns the captured result. Revision: 1.0               |
// +---------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH         = 64,
  parameter int ALU_CONTROL_WIDTH = 2,
  parameter int ALU_SELECT_WIDTH  = 3,
  parameter int DIV_LATENCY       = DIV_LATENCY_DEFAULT,
  parameter int TAG_WIDTH         = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [BUS_WIDTH-1:0]         req_in1,
  input  logic [BUS_WIDTH-1:0]         req_in2,
  input  logic [ALU_CONTROL_WIDTH-1:0] req_control,
  input  logic [ALU_SELECT_WIDTH-1:0]  req_select,
  input  logic [TAG_WIDTH-1:0]         req_tag,
  output logic [BUS_WIDTH-1:0]         alu_in1,
  output logic [BUS_WIDTH-1:0]         alu_in2,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
  output logic [ALU_SELECT_WIDTH-1:0]  alu_select,
  input  logic [BUS_WIDTH-1:0]         alu_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BUS_WIDTH-1:0]         rsp_data,
  output logic [TAG_WIDTH-1:0]         rsp_tag,
  output logic                         busy
);

  localparam int CNT_WIDTH = $clog2(DIV_LATENCY) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DIV_LATENCY - 1);

  state_t                 state;
  state_t                 state_next;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   accept;
  logic                   capture;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic [CNT_WIDTH-1:0]   cnt_value;
  logic                   req_is_div;

  assign req_is_div = (req_select == ALU_SELECT_WIDTH'(SEL_DIV));

  alu_wait_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (CNT_LOAD),
    .dec        (cnt_dec),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_is_div) begin
            cnt_load   = 1'b1;
            state_next = DIV_WAIT;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      // Counter starts at DIV_LATENCY-1, so this state lasts DIV_LATENCY cycles.
      DIV_WAIT: begin
        if (cnt_zero) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers only move on acceptance; the divider needs them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= '0;
      alu_select  <= '0;
      tag         <= '0;
    end else if (accept) begin
      alu_in1     <= req_in1;
      alu_in2     <= req_in2;
      alu_control <= req_control;
      alu_select  <= req_select;
      tag         <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_tag  <= '0;
    end else if (capture) begin
      rsp_data <= alu_out;
      rsp_tag  <= tag;
    end
  end

  assign req_ready = (state == IDLE) && rst_n;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_alu_issue_ctrl: directed self-checking bench with a behavioural ALU.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int BW  = 64;
  localparam int CW  = 2;
  localparam int SW  = 3;
  localparam int DL  = 64;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [BW-1:0] req_in1;
  logic [BW-1:0] req_in2;
  logic [CW-1:0] req_control;
  logic [SW-1:0] req_select;
  logic [TW-1:0] req_tag;
  logic [BW-1:0] alu_in1;
  logic [BW-1:0] alu_in2;
  logic [CW-1:0] alu_control;
  logic [SW-1:0] alu_select;
  logic [BW-1:0] alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .BUS_WIDTH         (BW),
    .ALU_CONTROL_WIDTH (CW),
    .ALU_SELECT_WIDTH  (SW),
    .DIV_LATENCY       (DL),
    .TAG_WIDTH         (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_control (req_control),
    .req_select  (req_select),
    .req_tag     (req_tag),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_control (alu_control),
    .alu_select  (alu_select),
    .alu_out     (alu_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .busy        (busy)
  );

  // Stand-in for the parent's ALU, driven only by the registered alu_* outputs.
  always_comb begin
    alu_out = '0;
    case (alu_select)
      3'b000:  alu_out = (alu_control == 2'b00) ? alu_in1 + alu_in2 : alu_in1 - alu_in2;
      3'b010:  alu_out = (alu_in2 != '0) ? alu_in1 / alu_in2 : '1;
      3'b011:  alu_out = alu_in1 << alu_in2[5:0];
      3'b110:  alu_out = alu_in1 ^ alu_in2;
      3'b111:  alu_out = alu_in1 & alu_in2;
      default: alu_out = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic [CW-1:0] ctl, input logic [SW-1:0] sel,
                           input logic [TW-1:0] t);
    req_valid   = 1'b1;
    req_in1     = a;
    req_in2     = b;
    req_control = ctl;
    req_select  = sel;
    req_tag     = t;
  endtask

  initial begin
    logic saw_rsp;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_in1     = '0;
    req_in2     = '0;
    req_control = '0;
    req_select  = '0;
    req_tag     = '0;
    rsp_ready   = 1'b0;

    tick();
    tick();
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_alu_in1",   alu_in1,            64'd0);
    check("rst_rsp_data",  rsp_data,           64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);

    // Add 5 + 7, tag 3.
    rsp_ready = 1'b1;
    drive_req(64'd5, 64'd7, 2'b00, 3'b000, 5'd3);
    tick();
    req_valid = 1'b0;
    check("add_exec_busy",  {63'd0, busy},      64'd1);
    check("add_exec_ready", {63'd0, req_ready}, 64'd0);
    check("add_exec_valid", {63'd0, rsp_valid}, 64'd0);
    check("add_alu_in1",    alu_in1,            64'd5);
    tick();
    check("add_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("add_rsp_data",  rsp_data,           64'd12);
    check("add_rsp_tag",   {59'd0, rsp_tag},   64'd3);
    tick();
    check("add_idle_busy",  {63'd0, busy},      64'd0);
    check("add_idle_valid", {63'd0, rsp_valid}, 64'd0);

    // Divide 100 / 7: no response for DL cycles, operands stable throughout.
    drive_req(64'd100, 64'd7, 2'b00, 3'b010, 5'd5);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < DL; i++) begin
      check("div_wait_valid", {63'd0, rsp_valid}, 64'd0);
      check("div_wait_in1",   alu_in1,            64'd100);
      check("div_wait_in2",   alu_in2,            64'd7);
      check("div_wait_sel",   {61'd0, alu_select}, 64'd2);
      tick();
    end
    check("div_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("div_rsp_data",  rsp_data,           64'd14);
    check("div_rsp_tag",   {59'd0, rsp_tag},   64'd5);
    tick();
    check("div_idle_busy", {63'd0, busy}, 64'd0);

    // XOR with 20 cycles of backpressure; a competing request is held up.
    rsp_ready = 1'b0;
    drive_req(64'hF0, 64'h0F, 2'b00, 3'b110, 5'd9);
    tick();
    drive_req(64'd1, 64'd2, 2'b00, 3'b000, 5'd4);
    tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_data",  rsp_data,           64'hFF);
      check("bp_tag",   {59'd0, rsp_tag},   64'd9);
      check("bp_ready", {63'd0, req_ready}, 64'd0);
      check("bp_in1",   alu_in1,            64'hF0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_hs_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_hs_ready", {63'd0, req_ready}, 64'd1);
    check("bp_hs_in1",   alu_in1,            64'hF0);
    tick();
    req_valid = 1'b0;
    check("bp_next_in1", alu_in1, 64'd1);
    tick();
    check("bp_next_data", rsp_data,         64'd3);
    check("bp_next_tag",  {59'd0, rsp_tag}, 64'd4);
    tick();

    // Back-to-back AND then shift-left with req_valid held high.
    drive_req(64'hFF00, 64'h0FF0, 2'b00, 3'b111, 5'd1);
    tick();
    drive_req(64'd1, 64'd4, 2'b00, 3'b011, 5'd2);
    tick();
    check("b2b_first_data",  rsp_data,           64'h0F00);
    check("b2b_first_tag",   {59'd0, rsp_tag},   64'd1);
    check("b2b_first_ready", {63'd0, req_ready}, 64'd0);
    tick();
    check("b2b_idle_ready", {63'd0, req_ready}, 64'd1);
    check("b2b_idle_in1",   alu_in1,            64'hFF00);
    tick();
    req_valid = 1'b0;
    check("b2b_second_in1", alu_in1, 64'd1);
    tick();
    check("b2b_second_valid", {63'd0, rsp_valid}, 64'd1);
    check("b2b_second_data",  rsp_data,           64'd16);
    check("b2b_second_tag",   {59'd0, rsp_tag},   64'd2);
    tick();

    // Reset pulse in the middle of a divide aborts it.
    drive_req(64'd100, 64'd7, 2'b00, 3'b010, 5'd7);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {63'd0, busy},        64'd0);
    check("arst_valid",  {63'd0, rsp_valid},   64'd0);
    check("arst_ready",  {63'd0, req_ready},   64'd0);
    check("arst_in1",    alu_in1,              64'd0);
    check("arst_sel",    {61'd0, alu_select},  64'd0);
    check("arst_data",   rsp_data,             64'd0);
    check("arst_tag",    {59'd0, rsp_tag},     64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("arst_release_ready", {63'd0, req_ready}, 64'd1);
    saw_rsp = 1'b0;
    for (int i = 0; i < DL + 10; i++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("arst_no_rsp", {63'd0, saw_rsp}, 64'd0);
    check("arst_idle",   {63'd0, busy},    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
